irq_arbiter: RTL and testbench

IRQ_ARBITER -- requirements
Module: irq_arbiter

---
 rtl/irq_arb_pkg.sv | 18 +
 rtl/irq_arbiter_rr_pick.sv | 36 +++
 rtl/irq_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_irq_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_arb_pkg.sv
// Shared definitions for the interrupt arbiter: FSM states, CPU register map, drain timeout.
package irq_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_VECTOR = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int unsigned TIMEOUT_MAX = 255;

endpackage

// File: rtl/irq_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit at or after ptr_i, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] sel_s;

    // Scan the requesters starting from the pointer position.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        sel_s   = '0;
        for (int k = 0; k < N; k++) begin
            sel_s = IW'((int'(ptr_i) + k) % N);
            if (!valid_o && req_i[sel_s]) begin
                valid_o = 1'b1;
                idx_o   = sel_s;
            end else begin
                valid_o = valid_o;
            end
        end
        if (valid_o) begin
            onehot_o = N'(1'b1) << idx_o;
        end else begin
            onehot_o = '0;
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Round-robin interrupt arbiter with a CPU register port (STATUS/VECTOR/MASK).
// Optional drain timeout with sticky error flag is enabled by defining IRQ_ARB_TIMEOUT_EN.
module irq_arbiter
    import irq_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   dev_ready,
    output logic [NREQ-1:0]   dev_ack,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [1:0]        cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              irq
);

    localparam int IW      = $clog2(NREQ);
    localparam int ERR_BIT = NREQ + 2;

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     grant_id_q, grant_id_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]   mask_q, mask_d;
    logic              err_q, err_d;
    logic              irq_q, irq_d;
    logic [NREQ-1:0]   ack_q, ack_d;
`ifdef IRQ_ARB_TIMEOUT_EN
    logic [7:0]        cnt_q, cnt_d;
`endif

    logic [NREQ-1:0]   eligible_s;
    logic [NREQ-1:0]   pick_onehot_unused_s;
    logic [IW-1:0]     pick_idx_s;
    logic              pick_valid_s;
    logic              vec_rd_s;
    logic [IW-1:0]     next_ptr_s;
    logic [DATA_W-1:0] status_s;
    logic              wdata_unused_s;

    assign eligible_s     = dev_ready & mask_q;
    assign vec_rd_s       = cpu_rd & ~cpu_wr & (cpu_addr == ADDR_VECTOR);
    assign next_ptr_s     = (grant_id_q == IW'(NREQ - 1)) ? '0 : grant_id_q + IW'(1);
    assign status_s       = DATA_W'({err_q, state_q, eligible_s});
    assign wdata_unused_s = ^cpu_wdata;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req_i    (eligible_s),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_onehot_unused_s),
        .idx_o    (pick_idx_s),
        .valid_o  (pick_valid_s)
    );

    // Next-state logic; a concurrent write suppresses the VECTOR-read transition.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        mask_d     = mask_q;
        err_d      = err_q;
`ifdef IRQ_ARB_TIMEOUT_EN
        cnt_d      = 8'd0;
`endif
        if (cpu_wr && (cpu_addr == ADDR_MASK)) begin
            mask_d = cpu_wdata[NREQ-1:0];
        end else begin
            mask_d = mask_q;
        end
`ifdef IRQ_ARB_TIMEOUT_EN
        if (cpu_wr && (cpu_addr == ADDR_STATUS) && cpu_wdata[ERR_BIT]) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
`else
        err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    grant_id_d = pick_idx_s;
                    state_d    = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (vec_rd_s) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_ACK: begin
                rr_ptr_d = next_ptr_s;
                state_d  = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!dev_ready[grant_id_q]) begin
                    state_d = ST_IDLE;
`ifdef IRQ_ARB_TIMEOUT_EN
                end else if (cnt_q == 8'(TIMEOUT_MAX - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`else
                end else begin
                    state_d = ST_DRAIN;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        irq_d = (state_d == ST_GRANT);
        if (state_d == ST_ACK) begin
            ack_d = NREQ'(1'b1) << grant_id_d;
        end else begin
            ack_d = '0;
        end
    end

    // CPU read mux; VECTOR is only meaningful while a grant is pending.
    always_comb begin
        cpu_rdata = '0;
        case (cpu_addr)
            ADDR_STATUS: cpu_rdata = status_s;
            ADDR_VECTOR: begin
                if (state_q == ST_GRANT) begin
                    cpu_rdata = DATA_W'(grant_id_q);
                end else begin
                    cpu_rdata = '1;
                end
            end
            ADDR_MASK:   cpu_rdata = DATA_W'(mask_q);
            ADDR_RSVD:   cpu_rdata = '0;
            default:     cpu_rdata = '0;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            mask_q     <= '1;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
            ack_q      <= '0;
`ifdef IRQ_ARB_TIMEOUT_EN
            cnt_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            mask_q     <= mask_d;
            err_q      <= err_d;
            irq_q      <= irq_d;
            ack_q      <= ack_d;
`ifdef IRQ_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign irq     = irq_q;
    assign dev_ack = ack_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed and randomized bench for irq_arbiter with a transaction-level round-robin model.
module tb_irq_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   dev_ready = '0;
    logic [NREQ-1:0]   dev_ack;
    logic              cpu_rd = 1'b0;
    logic              cpu_wr = 1'b0;
    logic [1:0]        cpu_addr = 2'd0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              irq;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int ptr_m  = 0;
    logic [3:0] mask_m = 4'hF;

    always #5 clk = ~clk;

    irq_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .dev_ready (dev_ready),
        .dev_ack   (dev_ack),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .irq       (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [15:0] d);
        cpu_addr = a;
        #1;
        d = cpu_rdata;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [15:0] v);
        cpu_wr    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = v;
        tick();
        cpu_wr    = 1'b0;
        cpu_wdata = '0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = 2'd0;
        cpu_wdata = '0;
        dev_ready = '0;
        tick();
        tick();
        rst    = 1'b0;
        ptr_m  = 0;
        mask_m = 4'hF;
    endtask

    // Round-robin rule: first eligible device at or after the pointer, wrapping.
    function automatic int rr_model(input logic [3:0] elig, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (elig[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic wait_irq();
        int n = 0;
        while (!irq && n < 20) begin
            tick();
            n++;
        end
        chk("irq_raised", irq, 1);
    endtask

    task automatic grant_and_ack(input int exp_id);
        logic [3:0] exp_ack;
        exp_ack = 4'b0001 << exp_id;
        wait_irq();
        cpu_addr = 2'd1;
        cpu_rd   = 1'b1;
        #1;
        chk("vector", cpu_rdata, exp_id);
        tick();
        cpu_rd = 1'b0;
        chk("ack_onehot", dev_ack, exp_ack);
        chk("irq_low_in_ack", irq, 0);
        tick();
        chk("ack_single_cycle", dev_ack, 0);
        ptr_m = (exp_id + 1) % NREQ;
    endtask

    task automatic serve(input int exp_id, input logic [3:0] after_ready);
        logic [3:0] bitm;
        logic [15:0] d;
        bitm = 4'b0001 << exp_id;
        grant_and_ack(exp_id);
        dev_ready = dev_ready & ~bitm;
        tick();
        read_reg(2'd0, d);
        chk("idle_after_drain", d[5:4], 0);
        dev_ready = after_ready;
    endtask

    initial begin
        logic [15:0] d;
        logic [3:0]  m;
        logic [3:0]  r;
        int          n;
        int          cnt;
        int          exp_id;

        // Reset state
        do_reset();
        chk("rst_irq", irq, 0);
        chk("rst_ack", dev_ack, 0);
        read_reg(2'd0, d);
        chk("rst_status", d, 16'h0000);
        read_reg(2'd2, d);
        chk("rst_mask", d, 16'h000F);

        // VECTOR read while idle
        cpu_rd = 1'b1;
        read_reg(2'd1, d);
        chk("vector_idle", d, 16'hFFFF);
        tick();
        cpu_rd = 1'b0;
        chk("vector_idle_no_irq", irq, 0);
        read_reg(2'd0, d);
        chk("vector_idle_state", d[5:4], 0);

        // Single requester: grant one cycle after ready
        dev_ready = 4'b0001;
        tick();
        chk("grant_latency", irq, 1);
        read_reg(2'd0, d);
        chk("status_grant", d, 16'h0011);
        serve(0, 4'b0000);

        // All requesters held: rotating order with wrap
        do_reset();
        dev_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            chk("rr_model_order", rr_model(dev_ready & mask_m, ptr_m), i);
            serve(i, 4'hF);
        end
        serve(0, 4'h0);

        // Masked requester stays silent, then wins once unmasked
        do_reset();
        write_reg(2'd2, 16'h000D);
        mask_m = 4'hD;
        dev_ready = 4'b0010;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (irq) cnt++;
        end
        chk("masked_no_irq", cnt, 0);
        read_reg(2'd0, d);
        chk("masked_status", d, 16'h0000);
        write_reg(2'd2, 16'h000F);
        mask_m = 4'hF;
        serve(1, 4'b0000);

        // Simultaneous read/write and masking during GRANT keep the grant
        dev_ready = 4'b0001;
        exp_id = rr_model(dev_ready & mask_m, ptr_m);
        wait_irq();
        cpu_rd = 1'b1;
        cpu_wr = 1'b1;
        cpu_addr = 2'd1;
        tick();
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        chk("rdwr_keeps_grant", irq, 1);
        chk("rdwr_no_ack", dev_ack, 0);
        write_reg(2'd2, 16'h0000);
        mask_m = 4'h0;
        chk("mask_keeps_grant", irq, 1);
        read_reg(2'd0, d);
        chk("mask_status", d, 16'h0010);
        serve(exp_id, 4'b0000);
        write_reg(2'd2, 16'h000F);
        mask_m = 4'hF;

        // Reserved address
        read_reg(2'd3, d);
        chk("rsvd_read", d, 16'h0000);
        write_reg(2'd3, 16'h0000);
        read_reg(2'd2, d);
        chk("rsvd_write_ignored", d, 16'h000F);

        // Reset in the middle of a grant
        do_reset();
        dev_ready = 4'b0100;
        wait_irq();
        rst = 1'b1;
        tick();
        chk("rst_drop_irq", irq, 0);
        chk("rst_no_ack", dev_ack, 0);
        read_reg(2'd0, d);
        chk("rst_status_elig", d, 16'h0004);
        rst = 1'b0;
        ptr_m = 0;
        mask_m = 4'hF;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (dev_ack != 4'b0000) cnt++;
        end
        chk("no_ack_after_rst", cnt, 0);
        serve(2, 4'b0000);

        // Randomized rounds against the model
        for (int i = 0; i < 24; i++) begin
            m = 4'($urandom_range(1, 15));
            r = 4'($urandom_range(0, 15));
            write_reg(2'd2, {12'h000, m});
            mask_m = m;
            dev_ready = r;
            read_reg(2'd0, d);
            chk("rand_status_elig", d[3:0], r & m);
            exp_id = rr_model(r & mask_m, ptr_m);
            if (exp_id < 0) begin
                cnt = 0;
                for (int j = 0; j < 4; j++) begin
                    tick();
                    if (irq) cnt++;
                end
                chk("rand_no_irq", cnt, 0);
                dev_ready = 4'b0000;
            end else begin
                serve(exp_id, 4'b0000);
            end
        end

        // Drain behaviour with a device that never drops ready
        do_reset();
        dev_ready = 4'b0100;
        grant_and_ack(2);
`ifdef IRQ_ARB_TIMEOUT_EN
        n = 0;
        read_reg(2'd0, d);
        while (d[5:4] == 2'd3 && n < 400) begin
            tick();
            n++;
            read_reg(2'd0, d);
        end
        chk("drain_timeout_len", n, 255);
        chk("timeout_err_set", d[6], 1);
        chk("timeout_idle", d[5:4], 0);
        write_reg(2'd0, 16'h0040);
        read_reg(2'd0, d);
        chk("err_cleared", d[6], 0);
        chk("regrant_model", rr_model(dev_ready & mask_m, ptr_m), 2);
        serve(2, 4'b0000);
`else
        for (int i = 0; i < 300; i++) tick();
        read_reg(2'd0, d);
        chk("drain_holds", d[5:4], 3);
        chk("no_err", d[6], 0);
        dev_ready = 4'b0000;
        tick();
        read_reg(2'd0, d);
        chk("drain_release", d[5:4], 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
